// File: rtl/boron_pkg.sv
// Shared constants and FSM state encoding for the encrypt/decrypt shuffle datapaths.
package boron_pkg;

  localparam int BLOCK_W   = 64;
  localparam int SAMPLE_W  = 16;
  localparam int N_SAMPLES = 4;
  localparam int SHUF_ROT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHUF = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Decryption-side small-block shuffle: rotate-right by SHUF_ROT, the inverse of the encrypt rotate.
  function automatic logic [SAMPLE_W-1:0] dec_small_block_shuffle(input logic [SAMPLE_W-1:0] s);
    return {s[SHUF_ROT-1:0], s[SAMPLE_W-1:SHUF_ROT]};
  endfunction

endpackage

// File: rtl/enc_small_block_shuffle.sv
// Encrypt small-block shuffle: one 16-bit sample rotated left by SHUF_ROT, purely combinational.
module enc_small_block_shuffle
  import boron_pkg::*;
(
  input  logic [SAMPLE_W-1:0] smp_i,
  output logic [SAMPLE_W-1:0] smp_o
);

  // Rotate-left: the top SHUF_ROT bits wrap around to the bottom.
  assign smp_o = {smp_i[SAMPLE_W-SHUF_ROT-1:0], smp_i[SAMPLE_W-1:SAMPLE_W-SHUF_ROT]};

endmodule

// File: rtl/enc_block_shuffle_unit.sv
// Block shuffle unit: latches a 64-bit block, runs its four samples serially through one
// shared rotate-left shuffle, then holds the result until the consumer takes it.
module enc_block_shuffle_unit #(
  parameter int N_SAMPLES = 4   // only 4 is supported (4 x 16-bit = 64-bit block)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_SAMPLES*boron_pkg::SAMPLE_W-1:0] in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [N_SAMPLES*boron_pkg::SAMPLE_W-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  localparam int SW = boron_pkg::SAMPLE_W;

  boron_pkg::state_e           state_q;
  logic [N_SAMPLES-1:0][SW-1:0] in_q;
  logic [N_SAMPLES-1:0][SW-1:0] out_q;
  logic [1:0]                   cnt_q;
  logic                         out_valid_q;
  logic [SW-1:0]                shuf_in;
  logic [SW-1:0]                shuf_out;

  // Single shared shuffle, fed by the sample selected by the counter.
  assign shuf_in = in_q[cnt_q];

  enc_small_block_shuffle u_shuf (
    .smp_i (shuf_in),
    .smp_o (shuf_out)
  );

  // Accept in IDLE, or in HOLD when the result is being taken this same cycle.
  assign in_ready = !rst && ((state_q == boron_pkg::ST_IDLE) ||
                             ((state_q == boron_pkg::ST_HOLD) && out_ready));

  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != boron_pkg::ST_IDLE);

  // Control FSM plus datapath registers; reset discards any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= boron_pkg::ST_IDLE;
      in_q        <= '0;
      out_q       <= '0;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        boron_pkg::ST_IDLE: begin
          if (in_valid) begin
            in_q    <= in_data;
            cnt_q   <= 2'd0;
            state_q <= boron_pkg::ST_SHUF;
          end
        end
        boron_pkg::ST_SHUF: begin
          out_q[cnt_q] <= shuf_out;
          cnt_q        <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_q     <= boron_pkg::ST_HOLD;
            out_valid_q <= 1'b1;
          end
        end
        boron_pkg::ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              // Back-to-back: next block starts with no idle cycle.
              in_q    <= in_data;
              cnt_q   <= 2'd0;
              state_q <= boron_pkg::ST_SHUF;
            end else begin
              state_q <= boron_pkg::ST_IDLE;
            end
          end
        end
        default: begin
          state_q     <= boron_pkg::ST_IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_block_shuffle_unit.sv
// Directed bench for enc_block_shuffle_unit with hand-computed expectations.
module tb_enc_block_shuffle_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  enc_block_shuffle_unit #(.N_SAMPLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decrypt-side inverse shuffle, written independently: rotate each sample right by 4.
  function automatic logic [63:0] unshuffle(input logic [63:0] b);
    logic [63:0] r;
    logic [15:0] s;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = b[16*k +: 16];
      r[16*k +: 16] = (s >> 4) | (s << 12);
    end
    return r;
  endfunction

  // Offer d from IDLE, then wait for out_valid; lat counts the accept cycle as 1.
  task automatic run_block(input logic [63:0] d, output logic [63:0] got, output int lat);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    got = out_data;
  endtask

  task automatic release_block();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [63:0] got;
  int          lat;
  int          t;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Basic vector, accepted on the first edge after reset.
    run_block(64'h0123_4567_89AB_CDEF, got, lat);
    chk("basic_latency", lat, 5);
    chk("basic_data", got, 64'h1230_5674_9AB8_DEFC);

    // Backpressure: 7 cycles held with out_ready low.
    in_valid = 1'b1;
    in_data  = 64'h1111_2222_3333_4444;
    for (int i = 0; i < 7; i++) begin
      chk("bp_in_ready", in_ready, 0);
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 64'h1230_5674_9AB8_DEFC);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    out_ready = 1'b0;
    chk("bp_released_valid", out_valid, 0);
    chk("bp_idle_busy", busy, 0);
    chk("bp_data_holds", out_data, 64'h1230_5674_9AB8_DEFC);

    // Back-to-back with in_valid and out_ready high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'hFFFF_0000_F000_000F;
    tick();
    in_data = 64'h8001_8001_8001_8001;
    t = 1;
    while (t < 5) begin
      chk("b2b_a_early_valid", out_valid, 0);
      tick();
      t++;
    end
    chk("b2b_a_valid", out_valid, 1);
    chk("b2b_a_data", out_data, 64'hFFFF_0000_000F_00F0);
    chk("b2b_hold_in_ready", in_ready, 1);
    tick();
    t++;
    in_valid = 1'b0;
    while (t < 10) begin
      chk("b2b_b_early_valid", out_valid, 0);
      chk("b2b_b_busy", busy, 1);
      tick();
      t++;
    end
    chk("b2b_b_valid", out_valid, 1);
    chk("b2b_b_data", out_data, 64'h0018_0018_0018_0018);
    tick();
    out_ready = 1'b0;
    chk("b2b_done_busy", busy, 0);

    // Reset during the second SHUF cycle discards the block.
    in_valid = 1'b1;
    in_data  = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_stays_invalid", out_valid, 0);
    end
    run_block(64'h0123_4567_89AB_CDEF, got, lat);
    chk("midrst_next_latency", lat, 5);
    chk("midrst_next_data", got, 64'h1230_5674_9AB8_DEFC);
    release_block();

    // Input offered during SHUF must be ignored.
    in_valid = 1'b1;
    in_data  = 64'h0123_4567_89AB_CDEF;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("ign_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    t = 3;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    chk("ign_latency", t, 5);
    chk("ign_data", out_data, 64'h1230_5674_9AB8_DEFC);
    release_block();

    // Round-trip through the decrypt shuffle.
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      run_block(d, got, lat);
      chk("rt_latency", lat, 5);
      chk("rt_data", unshuffle(got), d);
      release_block();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_block_shuffle_unit.md
ENC_BLOCK_SHUFFLE_UNIT -- requirements
Module: enc_block_shuffle_unit

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 4, the number of 16-bit samples per 64-bit block; only 4 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, 64, the plaintext-side block; sample k occupies bits [16k+15:16k].
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_data is presented.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-007 The block SHALL have port out_data, output, 64, the shuffled block.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_data holds a complete result.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes out_data this cycle.
REQ-010 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-011 The per-sample encryption shuffle SHALL be a rotate-left by 4 of each 16-bit sample: out = {in[11:0], in[15:12]}. It is the exact inverse of the decryption small-block shuffle (rotate-right by 4).
REQ-012 Samples SHALL be processed serially, one per cycle, in order 0,1,2,3, through a single shared shuffle instance.
REQ-013 The FSM SHALL have the states IDLE, SHUF and HOLD.
REQ-014 In IDLE, in_ready SHALL be 1; on in_valid&&in_ready, in_data SHALL be latched into an input register, the 2-bit sample counter cleared, and the FSM SHALL move to SHUF.
REQ-015 In SHUF, each cycle SHALL write the shuffled sample[cnt] into out_data[16cnt+15:16cnt] and increment cnt; when cnt==3, the FSM SHALL move to HOLD.
REQ-016 In HOLD, out_valid SHALL be 1 and out_data stable; on out_ready, the FSM SHALL return to IDLE, or go directly to SHUF if in_valid is also high that cycle.
REQ-017 in_ready SHALL be 1 in IDLE and in HOLD&&out_ready, and 0 otherwise; an input offered while in_ready=0 SHALL NOT be latched and need not be held stable by the block.
REQ-018 Latency SHALL be fixed: out_valid rises exactly 5 cycles after the accepting edge (1 latch + 4 SHUF), independent of data.
REQ-019 Sustained throughput with out_ready tied high SHALL be one block per 5 cycles, with no idle cycle between back-to-back blocks.
REQ-020 out_data SHALL hold its last value outside HOLD; consumers use it only while out_valid=1.
REQ-021 out_valid SHALL NOT drop in HOLD without out_ready (no retraction).
REQ-022 The counter SHALL not wrap within a block; it is reset to 0 on every accept.
REQ-023 Changes to in_data after acceptance SHALL NOT affect the block in flight.

Reset
REQ-024 When rst=1 at a clock edge: state=IDLE, cnt=0, input register=0, out_data=0, out_valid=0, busy=0; in_ready SHALL be 0 while rst is high.
REQ-025 Reset asserted mid-SHUF or in HOLD SHALL discard the block in flight with no partial output.
REQ-026 The first accept SHALL be possible on the first edge after rst deasserts.

Structure
REQ-027 Package boron_pkg SHALL hold BLOCK_W=64, SAMPLE_W=16, N_SAMPLES=4, SHUF_ROT=4 and the FSM state enum, shared with the decryption datapath.
REQ-028 Sub-module enc_small_block_shuffle (16-bit combinational rotate-left by SHUF_ROT) SHALL be instantiated once.

Verification
REQ-029 Basic: accept 64'h0123_4567_89AB_CDEF -> 5 cycles later out_valid=1, out_data=64'h1230_5674_9AB8_DEFC.
REQ-030 Round-trip: random 1000 blocks, with each output fed through the decryption block shuffle -> equals the original input.
REQ-031 Backpressure: out_ready=0 for 7 cycles in HOLD -> out_valid and out_data stable and in_ready=0 throughout; the block is released on the first out_ready=1.
REQ-032 Back-to-back: in_valid and out_ready held high, inputs 64'hFFFF_0000_F000_000F then 64'h8001_8001_8001_8001 -> results 64'hFFFF_0000_000F_00F0 and 64'h0018_0018_0018_0018, 5 cycles apart.
REQ-033 Reset mid-op: rst pulsed during cycle 2 of SHUF -> out_valid stays 0, out_data=0, the next accepted block is processed correctly.
REQ-034 Ignored input: in_valid pulsed with 64'hDEAD_BEEF_DEAD_BEEF during SHUF -> not latched; the in-flight result is unchanged.
